data_sram_responder: RTL
========================

// Module: data_sram_responder
// PURPOSE
//   Responder end of the data SRAM interface driven by the EXE stage. Accepts
//   the en/wen/addr/wdata request in the same cycle it is issued. Returns rdata
//   one cycle later, for the MEM stage to consume.
//   Writes are posted into a one-entry store buffer and retired to the word
//   array on the next cycle. Reads that hit the buffered word get merged data.
// PARAMETERS
//   DEPTH_LOG2  14             log2 of array depth in 32-bit words
//   BASE_ADDR   32'h0000_0000  byte base address; aligned to 4<<DEPTH_LOG2
// PORTS
//   clk              in   1   single clock; all state updates on posedge
//   reset            in   1   synchronous, active-high
//   data_sram_en     in   1   access request this cycle
//   data_sram_wen    in   4   byte write enables; 4'h0 with en = read
//   data_sram_addr   in   32  byte address; [1:0] ignored
//   data_sram_wdata  in   32  store data, byte lanes per wen
//   data_sram_rdata  out  32  read data, valid the cycle after a read request
//   data_sram_err    out  1   sticky out-of-range flag (DSRAM_ERR_CHECK_EN only)
// BEHAVIOUR
//   Reset: data_sram_rdata=0, store buffer valid=0, data_sram_err=0.
//     Array contents are not reset. Reset mid-operation discards a pending
//     buffered write: the write is lost, by design.
//   Index: idx = addr[DEPTH_LOG2+1:2]. In range iff
//     addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2].
//   No backpressure: a request is accepted every cycle en=1; no ready signal.
//   Read (en=1, wen=0) at cycle T:
//     - rdata at T+1 = array[idx], with buffer bytes substituted per buffer
//       wen when buffer valid at T and buf_idx==idx.
//     - rdata holds its value until the next read completes.
//       Writes and idle cycles do not change it.
//   Write (en=1, wen!=0) at cycle T:
//     - At the T edge: buffer loads {idx, wen, wdata}, valid=1.
//     - Any previously buffered entry retires to the array at that same edge:
//       byte-masked write of the old entry.
//     - rdata is unchanged.
//   Drain: at any edge with buffer valid and no new write, the entry retires
//     to the array and valid goes to 0.
//   Array: 1 read port + 1 byte-masked write port, both synchronous.
//     Retire and read in the same cycle never conflict.
//   Same-cycle read and write is impossible; one request per cycle.
//   Back-to-back writes to the same idx:
//     - Second entry replaces the buffer.
//     - The first entry retires in the same cycle.
//     - The final array value is the first write with the second write's
//       bytes overlaid.
//   Read after write, same idx, consecutive cycles: returns merged new data.
//     Unwritten bytes come from the array.
//   Out-of-range access:
//     - Write: discarded, never buffered.
//     - Read: returns 32'h0.
// CONFIGURATION
//   DSRAM_ERR_CHECK_EN defined:
//     - data_sram_err port exists.
//     - data_sram_err sets on any en=1 out-of-range access or misaligned
//       access (addr[1:0]!=0).
//     - It stays set until reset.
//     - Misaligned accesses still execute, with addr[1:0] ignored.
//   DSRAM_ERR_CHECK_EN undefined:
//     - Port absent; no error logic.
//     - Out-of-range behaviour above is unchanged.
// STRUCTURE
//   mycpu.h: DSRAM_DEPTH_LOG2 default; DSRAM_BUF_WD (buffer entry width =
//     DEPTH_LOG2+4+32).
//   Sub-module dsram_word_array:
//     - Synchronous byte-masked 1R1W RAM.
//     - Inferable as block RAM.
//   Top level holds:
//     - store buffer
//     - hit/merge logic
//     - rdata hold register
//     - error flag
// TESTING
//   1. Reset, then read 0x0 -> rdata=0x00000000 until the read completes;
//      err=0.
//   2. Write 0x10 wen=F wdata=0xDEADBEEF at T; read 0x10 at T+1
//      -> rdata=0xDEADBEEF at T+2, served from the buffer.
//   3. Write 0x20=0x11223344 (wen=F), idle 2 cycles, write 0x20 wen=4'b0010
//      wdata=0x0000AA00, idle, read 0x20 -> 0x1122AA44.
//   4. Back-to-back writes 0x30 wen=4'b0001 wdata=0x55 and 0x30 wen=4'b1000
//      wdata=0x66000000, then read 0x30 -> low byte 0x55, top byte 0x66.
//   5. Write 0x40=0xCAFEF00D, assert reset the next cycle, read 0x40 after
//      reset -> not 0xCAFEF00D if the array was previously 0 (buffer dropped);
//      rdata=0 during reset.
//   6. With DSRAM_ERR_CHECK_EN: read BASE_ADDR+(4<<DEPTH_LOG2) -> rdata=0,
//      err=1 and sticky; read 0x6 -> err stays 1.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: default array depth,
// store-buffer entry width and the byte-lane merge helper.
package data_sram_responder_pkg;

    // Default log2 depth of the word array
    localparam int DSRAM_DEPTH_LOG2 = 14;

    // Store-buffer entry width: {idx, wen, wdata}
    function automatic int dsram_buf_wd(input int depth_log2);
        return depth_log2 + 4 + 32;
    endfunction

    // Overlay the enabled byte lanes of upd onto base
    function automatic logic [31:0] byte_merge(
        input logic [31:0] base,
        input logic [31:0] upd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = upd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_responder_word_array.sv
// dsram_word_array: synchronous 1R1W word RAM with byte-masked writes.
// Ports: clk; rd_en_i/rd_idx_i -> rd_data_o (next cycle, held otherwise);
//        wr_be_i/wr_idx_i/wr_data_i (byte-masked write).
// Read returns the pre-write contents when both ports hit the same word.
module dsram_word_array #(
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [31:0]           rd_data_o,
    input  logic [3:0]            wr_be_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [31:0]           wr_data_i
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
        if (rd_en_i) rd_q <= mem_q[rd_idx_i];
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the EXE-stage data SRAM interface.
// Writes post to a one-entry store buffer and retire next cycle; reads
// return data the following cycle, merged with any buffered bytes.
// Ports: clk, reset (sync, active-high); data_sram_en/wen/addr/wdata in;
//        data_sram_rdata out; data_sram_err out (only with DSRAM_ERR_CHECK_EN).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = DSRAM_DEPTH_LOG2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata
`ifdef DSRAM_ERR_CHECK_EN
    ,
    output logic        data_sram_err
`endif
);

    localparam int AW     = DEPTH_LOG2;
    localparam int BUF_WD = dsram_buf_wd(DEPTH_LOG2);

    logic [AW-1:0] idx;
    logic          in_rng;
    logic          wr_go;
    logic          rd_go;

    assign idx    = data_sram_addr[AW+1:2];
    assign in_rng = data_sram_addr[31:AW+2] == BASE_ADDR[31:AW+2];
    // Out-of-range writes are dropped before they reach the buffer
    assign wr_go  = data_sram_en && (data_sram_wen != 4'h0) && in_rng;
    assign rd_go  = data_sram_en && (data_sram_wen == 4'h0);

    // Store buffer entry {idx, wen, wdata}
    logic [BUF_WD-1:0] buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic [AW-1:0]     buf_idx;
    logic [3:0]        buf_wen;
    logic [31:0]       buf_data;

    assign buf_idx  = buf_q[BUF_WD-1 -: AW];
    assign buf_wen  = buf_q[35:32];
    assign buf_data = buf_q[31:0];

    always_comb begin
        buf_d     = buf_q;
        buf_vld_d = 1'b0;
        if (wr_go) begin
            buf_d     = {idx, data_sram_wen, data_sram_wdata};
            buf_vld_d = 1'b1;
        end
    end

    // A valid entry retires at every edge; reset drops it instead
    logic [3:0] ram_we;
    logic [31:0] ram_rdata;

    assign ram_we = (buf_vld_q && !reset) ? buf_wen : 4'h0;

    dsram_word_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .rd_en_i  (rd_go && in_rng),
        .rd_idx_i (idx),
        .rd_data_o(ram_rdata),
        .wr_be_i  (ram_we),
        .wr_idx_i (buf_idx),
        .wr_data_i(buf_data)
    );

    // Read-side capture: the array returns pre-retire data, so the
    // buffer bytes seen at the read edge are overlaid afterwards.
    logic        rd_pend_q;
    logic        rd_hit_q;
    logic        rd_rng_q;
    logic [3:0]  rd_hwen_q;
    logic [31:0] rd_hdata_q;
    logic [31:0] hold_q, hold_d;
    logic [31:0] rd_merged;

    assign rd_merged = rd_rng_q
        ? byte_merge(ram_rdata, rd_hdata_q, rd_hit_q ? rd_hwen_q : 4'h0)
        : 32'h0;

    // rdata holds the last completed read until the next one lands
    assign hold_d          = rd_pend_q ? rd_merged : hold_q;
    assign data_sram_rdata = hold_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld_q <= 1'b0;
            buf_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_hit_q  <= 1'b0;
            rd_rng_q  <= 1'b0;
            rd_hwen_q <= 4'h0;
            rd_hdata_q <= 32'h0;
            hold_q    <= 32'h0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_q     <= buf_d;
            rd_pend_q <= rd_go;
            hold_q    <= hold_d;
            if (rd_go) begin
                rd_hit_q   <= buf_vld_q && (buf_idx == idx);
                rd_rng_q   <= in_rng;
                rd_hwen_q  <= buf_wen;
                rd_hdata_q <= buf_data;
            end
        end
    end

`ifdef DSRAM_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (data_sram_en &&
                     (!in_rng || data_sram_addr[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign data_sram_err = err_q;
`endif

    // Byte offset bits only matter for the error check
    logic unused_ok;
    assign unused_ok = ^data_sram_addr[1:0];

endmodule
